axi_ram_slave: RTL and testbench
================================

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, meaning the number of 32-bit words of backing store, power of two.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address mapped to word 0.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have ports arid/araddr/arlen/arsize/arburst/arvalid, input, 4/32/4/3/2/1, the AR request.
REQ-006 SHALL have port arready, output, 1, AR accept.
REQ-007 SHALL have ports rid/rdata/rresp/rlast/rvalid, output, 4/32/2/1/1, the R beat; rready, input, 1.
REQ-008 SHALL have ports awid/awaddr/awlen/awsize/awburst/awvalid, input, 4/32/4/3/2/1, the AW request; awready, output, 1.
REQ-009 SHALL have ports wdata/wstrb/wlast/wvalid, input, 32/4/1/1, the W beat; wready, output, 1.
REQ-010 SHALL have ports bid/bresp/bvalid, output, 4/2/1, the B response; bready, input, 1.

Function
REQ-011 SHALL run the read and write paths independently, with at most one outstanding burst per path.
REQ-012 SHALL implement the read FSM R_IDLE -> R_FETCH -> R_BEAT; R_IDLE asserts arready, and an AR handshake latches id, addr, len, size and burst.
REQ-013 SHALL assert rvalid exactly 1 cycle after the AR handshake (R_FETCH performs the synchronous RAM read).
REQ-014 SHALL hold rdata, rid, rresp and rlast stable while rvalid && !rready.
REQ-015 SHALL, on each R handshake with beats remaining, present the next beat 1 cycle later.
REQ-016 SHALL assert rlast on beat arlen+1.
REQ-017 SHALL return from R_BEAT to R_IDLE on the last R handshake, with arready high the following cycle.
REQ-018 SHALL implement the write FSM W_IDLE -> W_DATA -> W_RESP; W_IDLE asserts awready, and W_DATA asserts wready.
REQ-019 SHALL commit each W handshake to RAM that cycle, updating only the byte lanes whose wstrb bits are set.
REQ-020 SHALL count W beats and leave W_DATA after beat awlen+1.
REQ-021 SHALL assert bvalid in W_RESP, beginning the cycle after the last W handshake.
REQ-022 SHALL hold bvalid and bid until bready, then return to W_IDLE.
REQ-023 SHALL compute beat addresses by burst type:
  - FIXED: the address is constant.
  - INCR: the address advances by 2^size per beat.
  - WRAP: the address advances by 2^size and wraps within an aligned window of (len+1)*2^size bytes.
REQ-024 SHALL index RAM with word address ((addr-BASE_ADDR)>>2) mod MEM_WORDS.
REQ-025 SHALL treat any beat outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS) as an error beat:
  - read error beat: rdata 0, rresp SLVERR.
  - write error beat: write discarded; the burst's bresp becomes SLVERR.
REQ-026 SHALL treat arsize/awsize > 2 as an error on every beat of the burst.
REQ-027 SHALL return SLVERR in bresp if wlast disagrees with the beat count; the burst still ends on the counted beat.
REQ-028 SHALL return OKAY (2'b00) in rresp and bresp when no error occurs.
REQ-029 SHALL, when a write commits in cycle N, return the new data to any read whose RAM fetch occurs in cycle N+1 or later.
REQ-030 SHALL resolve a same-cycle write commit and read fetch to the same word by returning the old data to the read.

Reset
REQ-031 SHALL, with rst high at a clock edge, force both FSMs to IDLE and drive rvalid, bvalid, rlast and wready to 0 on the next cycle.
REQ-032 SHALL drive arready and awready to 1 in the first cycle after rst deasserts.
REQ-033 SHALL reset rid, bid, rdata and resp outputs to 0.
REQ-034 SHALL, when rst is asserted mid-burst, abandon the burst silently, issue no response, and preserve RAM contents.

Configuration
REQ-035 SHALL, with macro AXI_RAM_SLAVE_RANDOM_STALL_EN defined, gate arready, awready, wready, rvalid-issue and bvalid-issue each cycle by a 16-bit LFSR (seed 16'hACE1 on reset), stalling about 25% of cycles.
REQ-036 SHALL keep the stalls of REQ-035 AXI-legal: a valid once raised stays high until its handshake.
REQ-037 SHALL, without AXI_RAM_SLAVE_RANDOM_STALL_EN, have no stalls and exactly the latencies above.

Structure
REQ-038 SHALL take the burst encodings (FIXED/INCR/WRAP), the resp encodings (OKAY/SLVERR) and the FSM state typedefs from shared package axi_pkg.
REQ-039 SHALL implement the address computation of REQ-023 as sub-module axi_burst_addr_gen (inputs addr, len, size, burst; output next_addr), instantiated once per path.

Verification
REQ-040 SHALL cover a single write: AW addr 0x10, len 0, size 2, wdata 0xDEADBEEF, wstrb 4'hF -> bresp OKAY, bid = awid; a later read of 0x10 -> rdata 0xDEADBEEF, rlast 1.
REQ-041 SHALL cover an INCR read: len 3 from 0x100 -> 4 beats from 0x100/0x104/0x108/0x10C, rlast only on beat 4, first rvalid 1 cycle after the AR handshake.
REQ-042 SHALL cover a WRAP read: len 3, size 2, addr 0x38 -> beats from 0x38, 0x3C, 0x30, 0x34.
REQ-043 SHALL cover a partial write: wstrb 4'b0101, wdata 0x11223344, over 0xFFFFFFFF -> read back 0xFF22FF44.
REQ-044 SHALL cover out-of-range and size errors:
  - read at BASE_ADDR+4*MEM_WORDS -> rresp SLVERR, rdata 0.
  - awsize 3 -> bresp SLVERR and RAM unchanged.
REQ-045 SHALL cover reset mid-burst: rst during beat 2 of a len-7 read -> rvalid 0 the next cycle, arready 1 after release, prior RAM data intact.

Source files
------------

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI burst/resp encodings, FSM state types and beat error check
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_FETCH = 2'd1,
      R_BEAT  = 2'd2
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   // 33-bit subtraction so a borrow (addr below base) shows up in bit 32.
   function automatic logic beat_err(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [32:0] span,
                                     input logic [2:0]  size);
      logic [32:0] off;
      off = {1'b0, addr} - {1'b0, base};
      return off[32] || (off >= span) || (size > 3'd2);
   endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - next beat address for FIXED/INCR/WRAP bursts
module axi_burst_addr_gen
   import axi_pkg::*;
(
   input  logic [31:0] addr,
   input  logic [3:0]  len,
   input  logic [2:0]  size,
   input  logic [1:0]  burst,
   output logic [31:0] next_addr
);

   logic [31:0] incr;
   logic [31:0] incr_addr;
   logic [31:0] wrap_mask;

   always_comb begin
      incr      = 32'd1 << size;
      incr_addr = addr + incr;
      // WRAP window is (len+1) beats of 2^size bytes, aligned to its own size.
      wrap_mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
      next_addr = addr;
      case (burst)
         BURST_INCR: next_addr = incr_addr;
         BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
         default:    next_addr = addr;
      endcase
   end

endmodule

// File: rtl/axi_ram_slave.sv
// rtl/axi_ram_slave.sv - AXI burst RAM slave, independent read/write paths
// AXI_RAM_SLAVE_RANDOM_STALL_EN enables LFSR-driven handshake stalls.
module axi_ram_slave
   import axi_pkg::*;
#(
   parameter int          MEM_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [3:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [3:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int          IDX_W = $clog2(MEM_WORDS);
   localparam logic [32:0] SPAN  = 33'(MEM_WORDS) << 2;

   logic [31:0] mem_q [MEM_WORDS];

   logic rdy_stall;
   logic vld_stall;

`ifdef AXI_RAM_SLAVE_RANDOM_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= 16'hACE1;
      else     lfsr_q <= lfsr_d;
   end

   assign rdy_stall = (lfsr_q[1:0] == 2'b00);
   assign vld_stall = (lfsr_q[3:2] == 2'b00);
`else
   assign rdy_stall = 1'b0;
   assign vld_stall = 1'b0;
`endif

   // Read path state
   rd_state_e   r_state_q, r_state_d;
   logic [3:0]  rid_q, rid_d;
   logic [31:0] raddr_q, raddr_d;
   logic [3:0]  rlen_q, rlen_d;
   logic [3:0]  rbeat_q, rbeat_d;
   logic [2:0]  rsize_q, rsize_d;
   logic [1:0]  rburst_q, rburst_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic        rlast_q, rlast_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] raddr_next;
   logic [IDX_W-1:0] ridx;
   logic        rd_err;

   // Write path state
   wr_state_e   w_state_q, w_state_d;
   logic [3:0]  bid_q, bid_d;
   logic [31:0] waddr_q, waddr_d;
   logic [3:0]  wlen_q, wlen_d;
   logic [3:0]  wbeat_q, wbeat_d;
   logic [2:0]  wsize_q, wsize_d;
   logic [1:0]  wburst_q, wburst_d;
   logic        werr_q, werr_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        bvalid_q, bvalid_d;
   logic [31:0] waddr_next;
   logic [IDX_W-1:0] widx;
   logic        wr_err;
   logic        mem_we;

   axi_burst_addr_gen u_rd_addr_gen (
      .addr      (raddr_q),
      .len       (rlen_q),
      .size      (rsize_q),
      .burst     (rburst_q),
      .next_addr (raddr_next)
   );

   axi_burst_addr_gen u_wr_addr_gen (
      .addr      (waddr_q),
      .len       (wlen_q),
      .size      (wsize_q),
      .burst     (wburst_q),
      .next_addr (waddr_next)
   );

   assign ridx   = IDX_W'((raddr_q - BASE_ADDR) >> 2);
   assign widx   = IDX_W'((waddr_q - BASE_ADDR) >> 2);
   assign rd_err = beat_err(raddr_q, BASE_ADDR, SPAN, rsize_q);
   assign wr_err = beat_err(waddr_q, BASE_ADDR, SPAN, wsize_q);

   assign arready = (r_state_q == R_IDLE) && !rdy_stall;
   assign awready = (w_state_q == W_IDLE) && !rdy_stall;
   assign wready  = (w_state_q == W_DATA) && !rdy_stall;

   assign rid    = rid_q;
   assign rdata  = rdata_q;
   assign rresp  = rresp_q;
   assign rlast  = rlast_q;
   assign rvalid = rvalid_q;
   assign bid    = bid_q;
   assign bresp  = bresp_q;
   assign bvalid = bvalid_q;

   always_comb begin
      r_state_d = r_state_q;
      rid_d     = rid_q;
      raddr_d   = raddr_q;
      rlen_d    = rlen_q;
      rbeat_d   = rbeat_q;
      rsize_d   = rsize_q;
      rburst_d  = rburst_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rlast_d   = rlast_q;
      rvalid_d  = rvalid_q;
      case (r_state_q)
         R_IDLE: begin
            if (arvalid && arready) begin
               rid_d     = arid;
               raddr_d   = araddr;
               rlen_d    = arlen;
               rsize_d   = arsize;
               rburst_d  = arburst;
               rbeat_d   = 4'd0;
               r_state_d = R_FETCH;
            end
         end
         R_FETCH: begin
            // A write committed on this same edge is not yet visible: old data wins.
            if (!vld_stall) begin
               rdata_d   = rd_err ? 32'd0 : mem_q[ridx];
               rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
               rlast_d   = (rbeat_q == rlen_q);
               rvalid_d  = 1'b1;
               r_state_d = R_BEAT;
            end
         end
         R_BEAT: begin
            if (rready) begin
               rvalid_d = 1'b0;
               rlast_d  = 1'b0;
               if (rlast_q) begin
                  r_state_d = R_IDLE;
               end else begin
                  rbeat_d   = rbeat_q + 4'd1;
                  raddr_d   = raddr_next;
                  r_state_d = R_FETCH;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      w_state_d = w_state_q;
      bid_d     = bid_q;
      waddr_d   = waddr_q;
      wlen_d    = wlen_q;
      wbeat_d   = wbeat_q;
      wsize_d   = wsize_q;
      wburst_d  = wburst_q;
      werr_d    = werr_q;
      bresp_d   = bresp_q;
      bvalid_d  = bvalid_q;
      mem_we    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (awvalid && awready) begin
               bid_d     = awid;
               waddr_d   = awaddr;
               wlen_d    = awlen;
               wsize_d   = awsize;
               wburst_d  = awburst;
               wbeat_d   = 4'd0;
               werr_d    = 1'b0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (wvalid && wready) begin
               mem_we = !wr_err;
               werr_d = werr_q || wr_err || (wlast != (wbeat_q == wlen_q));
               if (wbeat_q == wlen_q) begin
                  bresp_d   = werr_d ? RESP_SLVERR : RESP_OKAY;
                  bvalid_d  = !vld_stall;
                  w_state_d = W_RESP;
               end else begin
                  wbeat_d = wbeat_q + 4'd1;
                  waddr_d = waddr_next;
               end
            end
         end
         W_RESP: begin
            if (!bvalid_q) begin
               bvalid_d = !vld_stall;
            end else if (bready) begin
               bvalid_d  = 1'b0;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q <= R_IDLE;
         rid_q     <= 4'd0;
         raddr_q   <= 32'd0;
         rlen_q    <= 4'd0;
         rbeat_q   <= 4'd0;
         rsize_q   <= 3'd0;
         rburst_q  <= 2'd0;
         rdata_q   <= 32'd0;
         rresp_q   <= RESP_OKAY;
         rlast_q   <= 1'b0;
         rvalid_q  <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         rid_q     <= rid_d;
         raddr_q   <= raddr_d;
         rlen_q    <= rlen_d;
         rbeat_q   <= rbeat_d;
         rsize_q   <= rsize_d;
         rburst_q  <= rburst_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
         rvalid_q  <= rvalid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         bid_q     <= 4'd0;
         waddr_q   <= 32'd0;
         wlen_q    <= 4'd0;
         wbeat_q   <= 4'd0;
         wsize_q   <= 3'd0;
         wburst_q  <= 2'd0;
         werr_q    <= 1'b0;
         bresp_q   <= RESP_OKAY;
         bvalid_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         bid_q     <= bid_d;
         waddr_q   <= waddr_d;
         wlen_q    <= wlen_d;
         wbeat_q   <= wbeat_d;
         wsize_q   <= wsize_d;
         wburst_q  <= wburst_d;
         werr_q    <= werr_d;
         bresp_q   <= bresp_d;
         bvalid_q  <= bvalid_d;
      end
   end

   // RAM is never reset; a burst cut short by rst must not commit its last beat.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_ram_slave.sv
// tb/tb_axi_ram_slave.sv - directed table-driven bench for axi_ram_slave
module tb_axi_ram_slave;
   import axi_pkg::*;

   logic        clk;
   logic        rst;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   axi_ram_slave dut (
      .clk     (clk),
      .rst     (rst),
      .arid    (arid),
      .araddr  (araddr),
      .arlen   (arlen),
      .arsize  (arsize),
      .arburst (arburst),
      .arvalid (arvalid),
      .arready (arready),
      .rid     (rid),
      .rdata   (rdata),
      .rresp   (rresp),
      .rlast   (rlast),
      .rvalid  (rvalid),
      .rready  (rready),
      .awid    (awid),
      .awaddr  (awaddr),
      .awlen   (awlen),
      .awsize  (awsize),
      .awburst (awburst),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wlast   (wlast),
      .wvalid  (wvalid),
      .wready  (wready),
      .bid     (bid),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [3:0]  id;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t vecs [15];

   int tests;
   int fails;

   logic [31:0] rd_data [16];
   logic [1:0]  rd_resp [16];
   logic        rd_last [16];
   logic [3:0]  rd_id   [16];
   logic [1:0]  wr_resp;
   logic [3:0]  wr_bid;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: got no handshake expected one within 50 cycles", name);
   endtask

   task automatic ar_handshake(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
      logic hs;
      int   n;
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
      arvalid = 1'b1;
      hs = 1'b0;
      n  = 0;
      while (!hs && n < 50) begin
         hs = arready;
         tick();
         n++;
      end
      arvalid = 1'b0;
      if (!hs) timeout("ar_handshake");
   endtask

   task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
      int n;
      ar_handshake(id, addr, len, size, burst);
      tick();
      check("r_first_latency", 32'(rvalid), 32'd1);
      rready = 1'b1;
      for (int i = 0; i <= int'(len); i++) begin
         n = 0;
         while (!rvalid && n < 50) begin
            tick();
            n++;
         end
         if (!rvalid) begin
            timeout("r_beat");
            break;
         end
         rd_data[i] = rdata;
         rd_resp[i] = rresp;
         rd_last[i] = rlast;
         rd_id[i]   = rid;
         tick();
      end
      rready = 1'b0;
   endtask

   task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic [31:0] base, input logic [3:0] strb, input int last_beat);
      logic hs;
      int   n;
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
      awvalid = 1'b1;
      hs = 1'b0;
      n  = 0;
      while (!hs && n < 50) begin
         hs = awready;
         tick();
         n++;
      end
      awvalid = 1'b0;
      if (!hs) begin
         timeout("aw_handshake");
         return;
      end
      for (int i = 0; i <= int'(len); i++) begin
         wdata  = base + 32'(i);
         wstrb  = strb;
         wlast  = (i == last_beat);
         wvalid = 1'b1;
         hs = 1'b0;
         n  = 0;
         while (!hs && n < 50) begin
            hs = wready;
            tick();
            n++;
         end
         if (!hs) begin
            wvalid = 1'b0;
            wlast  = 1'b0;
            timeout("w_handshake");
            return;
         end
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
      check("b_latency", 32'(bvalid), 32'd1);
      n = 0;
      while (!bvalid && n < 50) begin
         tick();
         n++;
      end
      wr_resp = bresp;
      wr_bid  = bid;
      bready  = 1'b1;
      tick();
      bready  = 1'b0;
      check("b_done_awready", 32'(awready), 32'd1);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
      rready = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
      bready = 1'b0;

      //            wr    id     addr           size  data           strb     exp_data       exp_resp
      vecs[0]  = '{1'b1, 4'h3, 32'h0000_0010, 3'd2, 32'hDEADBEEF, 4'hF,    32'h0,         RESP_OKAY};
      vecs[1]  = '{1'b0, 4'h5, 32'h0000_0010, 3'd2, 32'h0,        4'h0,    32'hDEADBEEF,  RESP_OKAY};
      vecs[2]  = '{1'b1, 4'h1, 32'h0000_0020, 3'd2, 32'hFFFFFFFF, 4'hF,    32'h0,         RESP_OKAY};
      vecs[3]  = '{1'b1, 4'h2, 32'h0000_0020, 3'd2, 32'h11223344, 4'b0101, 32'h0,         RESP_OKAY};
      vecs[4]  = '{1'b0, 4'h6, 32'h0000_0020, 3'd2, 32'h0,        4'h0,    32'hFF22FF44,  RESP_OKAY};
      vecs[5]  = '{1'b0, 4'h7, 32'h0000_4000, 3'd2, 32'h0,        4'h0,    32'h0,         RESP_SLVERR};
      vecs[6]  = '{1'b1, 4'h4, 32'h0000_0030, 3'd2, 32'h01234567, 4'hF,    32'h0,         RESP_OKAY};
      vecs[7]  = '{1'b1, 4'h8, 32'h0000_0030, 3'd3, 32'hCAFEF00D, 4'hF,    32'h0,         RESP_SLVERR};
      vecs[8]  = '{1'b0, 4'h9, 32'h0000_0030, 3'd2, 32'h0,        4'h0,    32'h01234567,  RESP_OKAY};
      vecs[9]  = '{1'b0, 4'hA, 32'h0000_0030, 3'd3, 32'h0,        4'h0,    32'h0,         RESP_SLVERR};
      vecs[10] = '{1'b1, 4'hB, 32'h0000_0004, 3'd2, 32'hAAAA5555, 4'hF,    32'h0,         RESP_OKAY};
      vecs[11] = '{1'b1, 4'hC, 32'h0000_4004, 3'd2, 32'h12345678, 4'hF,    32'h0,         RESP_SLVERR};
      vecs[12] = '{1'b0, 4'hD, 32'h0000_0004, 3'd2, 32'h0,        4'h0,    32'hAAAA5555,  RESP_OKAY};
      vecs[13] = '{1'b0, 4'hE, 32'h0000_0010, 3'd0, 32'h0,        4'h0,    32'hDEADBEEF,  RESP_OKAY};
      vecs[14] = '{1'b1, 4'hF, 32'hFFFF_FFFC, 3'd2, 32'h55555555, 4'hF,    32'h0,         RESP_SLVERR};

      tick();
      tick();
      tick();
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_bvalid", 32'(bvalid), 32'd0);
      check("rst_rlast",  32'(rlast),  32'd0);
      check("rst_wready", 32'(wready), 32'd0);
      check("rst_rdata",  rdata, 32'd0);
      check("rst_resps",  32'({rresp, bresp}), 32'd0);
      check("rst_ids",    32'({rid, bid}), 32'd0);
      rst = 1'b0;
      tick();
      check("post_rst_arready", 32'(arready), 32'd1);
      check("post_rst_awready", 32'(awready), 32'd1);

      for (int v = 0; v < 15; v++) begin
         if (vecs[v].wr) begin
            write_burst(vecs[v].id, vecs[v].addr, 4'd0, vecs[v].size, BURST_INCR,
                        vecs[v].data, vecs[v].strb, 0);
            check($sformatf("vec%0d_bresp", v), 32'(wr_resp), 32'(vecs[v].exp_resp));
            check($sformatf("vec%0d_bid", v),   32'(wr_bid),  32'(vecs[v].id));
         end else begin
            read_burst(vecs[v].id, vecs[v].addr, 4'd0, vecs[v].size, BURST_INCR);
            check($sformatf("vec%0d_rdata", v), rd_data[0], vecs[v].exp_data);
            check($sformatf("vec%0d_rresp", v), 32'(rd_resp[0]), 32'(vecs[v].exp_resp));
            check($sformatf("vec%0d_rlast", v), 32'(rd_last[0]), 32'd1);
            check($sformatf("vec%0d_rid", v),   32'(rd_id[0]), 32'(vecs[v].id));
         end
      end

      // INCR burst write then read back 0x100..0x10C
      write_burst(4'h1, 32'h100, 4'd3, 3'd2, BURST_INCR, 32'hA000_0000, 4'hF, 3);
      check("incr_wr_bresp", 32'(wr_resp), 32'(RESP_OKAY));
      read_burst(4'h2, 32'h100, 4'd3, 3'd2, BURST_INCR);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("incr_beat%0d_data", i), rd_data[i], 32'hA000_0000 + 32'(i));
         check($sformatf("incr_beat%0d_last", i), 32'(rd_last[i]), 32'(i == 3));
      end

      // WRAP read across a 16-byte window starting mid-window
      write_burst(4'h3, 32'h30, 4'd3, 3'd2, BURST_INCR, 32'h0000_00B0, 4'hF, 3);
      check("wrap_wr_bresp", 32'(wr_resp), 32'(RESP_OKAY));
      read_burst(4'h4, 32'h38, 4'd3, 3'd2, BURST_WRAP);
      check("wrap_beat0", rd_data[0], 32'hB2);
      check("wrap_beat1", rd_data[1], 32'hB3);
      check("wrap_beat2", rd_data[2], 32'hB0);
      check("wrap_beat3", rd_data[3], 32'hB1);

      read_burst(4'h5, 32'h34, 4'd2, 3'd2, BURST_FIXED);
      check("fixed_beat0", rd_data[0], 32'hB1);
      check("fixed_beat2", rd_data[2], 32'hB1);
      check("fixed_last",  32'(rd_last[2]), 32'd1);

      // wlast early, then wlast missing: SLVERR but burst still runs to the counted beat
      write_burst(4'h6, 32'h200, 4'd1, 3'd2, BURST_INCR, 32'h0, 4'hF, 0);
      check("wlast_early_bresp", 32'(wr_resp), 32'(RESP_SLVERR));
      write_burst(4'h7, 32'h200, 4'd1, 3'd2, BURST_INCR, 32'h0, 4'hF, 99);
      check("wlast_missing_bresp", 32'(wr_resp), 32'(RESP_SLVERR));

      // Reset during beat 2 of a len-7 read
      write_burst(4'h8, 32'h300, 4'd7, 3'd2, BURST_INCR, 32'h0000_00C0, 4'hF, 7);
      check("rstmid_wr_bresp", 32'(wr_resp), 32'(RESP_OKAY));
      ar_handshake(4'h9, 32'h300, 4'd7, 3'd2, BURST_INCR);
      rready = 1'b1;
      for (int k = 0; k < 50 && !rvalid; k++) tick();
      tick();
      for (int k = 0; k < 50 && !rvalid; k++) tick();
      check("rstmid_beat2_valid", 32'(rvalid), 32'd1);
      check("rstmid_beat2_data",  rdata, 32'hC1);
      rready = 1'b0;
      rst    = 1'b1;
      tick();
      check("rstmid_rvalid", 32'(rvalid), 32'd0);
      check("rstmid_rlast",  32'(rlast),  32'd0);
      rst = 1'b0;
      tick();
      check("rstmid_arready", 32'(arready), 32'd1);
      check("rstmid_bvalid",  32'(bvalid),  32'd0);
      read_burst(4'hA, 32'h304, 4'd0, 3'd2, BURST_INCR);
      check("rstmid_ram_304", rd_data[0], 32'hC1);
      read_burst(4'hB, 32'h31C, 4'd0, 3'd2, BURST_INCR);
      check("rstmid_ram_31c", rd_data[0], 32'hC7);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish before 500000");
      $fatal(1);
   end

endmodule
